// File: rtl/noc_out_arbiter_pkg.sv
// noc_pkg: shared definitions for the NoC output-port arbiter.
//   - flit index constants inside a packet (header, size)
//   - FSM state enumeration (IDLE, HDR, SIZE, PAYLOAD)
//   - default flit width
package noc_pkg;

  localparam int FLIT_W_DEF    = 16;
  localparam int HDR_FLIT_IDX  = 0;
  localparam int SIZE_FLIT_IDX = 1;

  // HDR/SIZE encodings follow the flit position within the packet.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'(HDR_FLIT_IDX + 1),
    S_SIZE    = 2'(SIZE_FLIT_IDX + 1),
    S_PAYLOAD = 2'd3
  } noc_state_e;

endpackage

// File: rtl/noc_out_arbiter_if.sv
// noc_out_arbiter_if: bundle of the arbiter's per-port request side and the
// output link.
//   in_rx     per-port flit valid           in_data   packed per-port flits
//   in_credit per-port accept               tx        output-link valid
//   data_out  output-link flit              credit_i  downstream has space
//   grant     one-hot current link owner
// master: the requesters/downstream side; slave: the arbiter.
interface noc_out_arbiter_if import noc_pkg::*; #(
  parameter int NPORTS = 4,
  parameter int FLIT_W = FLIT_W_DEF
);
  logic [NPORTS-1:0]        in_rx;
  logic [NPORTS*FLIT_W-1:0] in_data;
  logic [NPORTS-1:0]        in_credit;
  logic                     tx;
  logic [FLIT_W-1:0]        data_out;
  logic                     credit_i;
  logic [NPORTS-1:0]        grant;

  modport master (
    output in_rx, in_data, credit_i,
    input  in_credit, tx, data_out, grant
  );

  modport slave (
    input  in_rx, in_data, credit_i,
    output in_credit, tx, data_out, grant
  );
endinterface

// File: rtl/noc_rr_picker.sv
// noc_rr_picker: combinational round-robin select.
//   req_i  request vector
//   ptr_i  highest-priority port index
//   gnt_o  one-hot: first requesting port at or after ptr_i (wrapping), 0 if none
module noc_rr_picker #(
  parameter int NPORTS = 4,
  parameter int PW     = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [PW-1:0]     ptr_i,
  output logic [NPORTS-1:0] gnt_o
);

  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;

  // Scan ports starting at ptr_i; the first hit wins and masks later ones.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      sum_s = {1'b0, ptr_i} + (PW+1)'(k);
      // ptr_i < NPORTS and k < NPORTS, so a single subtract wraps.
      if (sum_s >= (PW+1)'(NPORTS)) begin
        sum_s = sum_s - (PW+1)'(NPORTS);
      end else begin
        sum_s = sum_s;
      end
      idx_s        = sum_s[PW-1:0];
      hit_s        = ~found_s & req_i[idx_s];
      gnt_o[idx_s] = gnt_o[idx_s] | hit_s;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter: packet-granular round-robin arbiter for one NoC output link.
//   clk        clock
//   rst        asynchronous active-low reset
//   bus        noc_out_arbiter_if.slave (requests, output link, grant)
//   pkt_count  completed-packet counter, present only with NOC_ARB_STATS_EN
// Packet: header flit, size flit S, then S payload flits. Once granted, a
// port keeps the link until its last flit moves; the link path is a
// zero-latency passthrough from the granted port.
module noc_out_arbiter import noc_pkg::*; #(
  parameter int NPORTS = 4,
  parameter int FLIT_W = FLIT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  noc_out_arbiter_if.slave   bus
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [15:0]        pkt_count
`endif
);

  localparam int PW = $clog2(NPORTS);

  localparam logic [1:0] ST_IDLE    = 2'(S_IDLE);
  localparam logic [1:0] ST_HDR     = 2'(S_HDR);
  localparam logic [1:0] ST_SIZE    = 2'(S_SIZE);
  localparam logic [1:0] ST_PAYLOAD = 2'(S_PAYLOAD);

  logic [1:0]        state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [FLIT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NPORTS-1:0] pick_s;
  logic [PW-1:0]     g_idx_s;
  logic              tx_s;
  logic [FLIT_W-1:0] data_s;
  logic [NPORTS-1:0] credit_s;
  logic              xfer_s;
  logic              pkt_end_s;

  noc_rr_picker #(.NPORTS(NPORTS), .PW(PW)) u_picker (
    .req_i (bus.in_rx),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_s)
  );

  // One-hot grant to binary port index.
  always_comb begin
    g_idx_s = '0;
    for (int i = 0; i < NPORTS; i++) begin
      g_idx_s = g_idx_s | (grant_q[i] ? PW'(i) : '0);
    end
  end

  // Passthrough from the owning port to the link; silent while idle.
  always_comb begin
    tx_s     = 1'b0;
    data_s   = '0;
    credit_s = '0;
    if (state_q != ST_IDLE) begin
      tx_s              = bus.in_rx[g_idx_s];
      data_s            = bus.in_data[g_idx_s*FLIT_W +: FLIT_W];
      credit_s[g_idx_s] = bus.in_rx[g_idx_s] & bus.credit_i;
    end else begin
      tx_s     = 1'b0;
      data_s   = '0;
      credit_s = '0;
    end
    xfer_s = tx_s & bus.credit_i;
  end

  // Packet FSM: arbitration in IDLE, then header/size/payload tracking.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_end_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.in_rx) begin
          grant_d = pick_s;
          state_d = ST_HDR;
        end else begin
          grant_d = '0;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          state_d = ST_SIZE;
        end else begin
          state_d = state_q;
        end
      end
      ST_SIZE: begin
        if (xfer_s) begin
          cnt_d = data_s;
          if (data_s == '0) begin
            state_d   = ST_IDLE;
            pkt_end_s = 1'b1;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_PAYLOAD: begin
        if (xfer_s) begin
          cnt_d = cnt_q - FLIT_W'(1);
          if (cnt_q == FLIT_W'(1)) begin
            state_d   = ST_IDLE;
            pkt_end_s = 1'b1;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    // Release the link and move priority just past the finishing port.
    if (pkt_end_s) begin
      grant_d  = '0;
      rr_ptr_d = (g_idx_s == PW'(NPORTS - 1)) ? '0 : g_idx_s + PW'(1);
    end else begin
      rr_ptr_d = rr_ptr_d;
    end
  end

  // FSM, grant, counter and priority pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.tx        = tx_s;
  assign bus.data_out  = data_s;
  assign bus.in_credit = credit_s;
  assign bus.grant     = grant_q;

`ifdef NOC_ARB_STATS_EN
  logic [15:0] pkt_count_q;

  // Completed-packet counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count_q <= 16'd0;
    end else if (pkt_end_s) begin
      pkt_count_q <= pkt_count_q + 16'd1;
    end else begin
      pkt_count_q <= pkt_count_q;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed testbench for noc_out_arbiter (NPORTS=4, FLIT_W=16).
module tb_noc_out_arbiter;
  import noc_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  noc_out_arbiter_if #(.NPORTS(4), .FLIT_W(16)) bus_if ();

`ifdef NOC_ARB_STATS_EN
  logic [15:0] pkt_count;
  noc_out_arbiter #(.NPORTS(4), .FLIT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .pkt_count (pkt_count)
  );
`else
  noc_out_arbiter #(.NPORTS(4), .FLIT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Check all link outputs at once.
  task automatic chk_link(input string tag, input logic [3:0] g, input logic t,
                          input logic [15:0] d, input logic [3:0] c);
    chk({tag, ".grant"},     32'(bus_if.grant),     32'(g));
    chk({tag, ".tx"},        32'(bus_if.tx),        32'(t));
    chk({tag, ".data_out"},  32'(bus_if.data_out),  32'(d));
    chk({tag, ".in_credit"}, 32'(bus_if.in_credit), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_flit(input int p, input logic [15:0] v);
    bus_if.in_data[p*16 +: 16] = v;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus_if.in_rx    = 4'b0000;
    bus_if.in_data  = 64'h0;
    bus_if.credit_i = 1'b1;
    #3;
    chk_link("reset", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single requester on port 2, two payload flits.
    bus_if.in_rx = 4'b0100;
    set_flit(2, 16'h0011);
    #1;
    chk_link("p2_arb", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    tick();
    #1;
    chk_link("p2_hdr", 4'b0100, 1'b1, 16'h0011, 4'b0100);
    tick();
    set_flit(2, 16'h0002);
    #1;
    chk_link("p2_size", 4'b0100, 1'b1, 16'h0002, 4'b0100);
    tick();
    set_flit(2, 16'hAAAA);
    #1;
    chk_link("p2_pay0", 4'b0100, 1'b1, 16'hAAAA, 4'b0100);
    tick();
    set_flit(2, 16'hBBBB);
    #1;
    chk_link("p2_pay1", 4'b0100, 1'b1, 16'hBBBB, 4'b0100);
    tick();
    bus_if.in_rx = 4'b0000;
    #1;
    chk_link("p2_idle", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    tick();

    // Restart from reset, ports 0 and 1 compete.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus_if.in_rx = 4'b0011;
    set_flit(0, 16'h1000);
    set_flit(1, 16'h2000);
    tick();
    #1;
    chk_link("p01_hdr0", 4'b0001, 1'b1, 16'h1000, 4'b0001);
    tick();
    set_flit(0, 16'h0000);
    #1;
    chk_link("p01_size0", 4'b0001, 1'b1, 16'h0000, 4'b0001);
    tick();
    #1;
    chk_link("p01_idle0", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    set_flit(0, 16'h1000);
    tick();
    #1;
    chk_link("p01_hdr1", 4'b0010, 1'b1, 16'h2000, 4'b0010);
    tick();
    set_flit(1, 16'h0001);
    #1;
    chk_link("p01_size1", 4'b0010, 1'b1, 16'h0001, 4'b0010);
    tick();
    set_flit(1, 16'h2222);
    #1;
    chk_link("p01_pay1", 4'b0010, 1'b1, 16'h2222, 4'b0010);
    tick();
    #1;
    chk_link("p01_idle1", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    tick();
    #1;
    chk_link("p01_wrap", 4'b0001, 1'b1, 16'h1000, 4'b0001);
    tick();
    set_flit(0, 16'h0000);
    tick();
    // Now idle with rr_ptr=1; only port 3 requests.
    bus_if.in_rx = 4'b1000;
    set_flit(3, 16'h3000);
    #1;
    chk_link("p01_idle2", 4'b0000, 1'b0, 16'h0000, 4'b0000);

    // Port 3 with a credit stall and an in_rx bubble mid-payload.
    tick();
    #1;
    chk_link("p3_hdr", 4'b1000, 1'b1, 16'h3000, 4'b1000);
    tick();
    set_flit(3, 16'h0003);
    tick();
    set_flit(3, 16'h3001);
    #1;
    chk_link("p3_pay0", 4'b1000, 1'b1, 16'h3001, 4'b1000);
    tick();
    set_flit(3, 16'h3002);
    bus_if.credit_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_link("p3_stall", 4'b1000, 1'b1, 16'h3002, 4'b0000);
      tick();
    end
    bus_if.credit_i = 1'b1;
    bus_if.in_rx    = 4'b0000;
    #1;
    chk_link("p3_bubble", 4'b1000, 1'b0, 16'h3002, 4'b0000);
    tick();
    bus_if.in_rx = 4'b1000;
    #1;
    chk_link("p3_pay1", 4'b1000, 1'b1, 16'h3002, 4'b1000);
    tick();
    set_flit(3, 16'h3003);
    #1;
    chk_link("p3_pay2", 4'b1000, 1'b1, 16'h3003, 4'b1000);
    tick();
    bus_if.in_rx = 4'b0010;
    set_flit(1, 16'h4000);
    #1;
    chk_link("p3_idle", 4'b0000, 1'b0, 16'h0000, 4'b0000);
`ifdef NOC_ARB_STATS_EN
    chk("pkt_count", 32'(pkt_count), 32'd4);
`endif

    // Reset in the middle of a payload with cnt=5.
    tick();
    #1;
    chk_link("p1_hdr", 4'b0010, 1'b1, 16'h4000, 4'b0010);
    tick();
    set_flit(1, 16'h0005);
    tick();
    set_flit(1, 16'h4001);
    #1;
    chk_link("p1_pay0", 4'b0010, 1'b1, 16'h4001, 4'b0010);
    rst = 1'b0;
    #1;
    chk_link("rst_mid", 4'b0000, 1'b0, 16'h0000, 4'b0000);
`ifdef NOC_ARB_STATS_EN
    chk("pkt_count_rst", 32'(pkt_count), 32'd0);
`endif
    bus_if.in_rx = 4'b0011;
    set_flit(0, 16'h5000);
    tick();
    chk_link("rst_hold", 4'b0000, 1'b0, 16'h0000, 4'b0000);
    rst = 1'b1;
    tick();
    #1;
    chk_link("rst_restart", 4'b0001, 1'b1, 16'h5000, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
